// File: rtl/jk_sync.sv
// Bank of WIDTH independent JK flip-flops sharing one clock and a synchronous active-low reset.
// Qn is taken straight from the Q register, so it never lags Q.
module jk_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Each slice follows the JK truth table: hold, clear, set or toggle.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({J[i], K[i]})
        2'b00:   q_d[i] = q_q[i];
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: tb/tb_jk_sync.sv
// Directed bench for jk_sync: a 4-bit instance driven from a vector table and a
// default 1-bit instance exercised with hand-written multi-cycle sequences.
module tb_jk_sync;

  logic       clk;
  logic       rst4;
  logic [3:0] j4;
  logic [3:0] k4;
  logic [3:0] q4;
  logic [3:0] qn4;

  logic       rst1;
  logic       j1;
  logic       k1;
  logic       q1;
  logic       qn1;

  int pass_count;
  int check_count;

  typedef struct {
    logic       rst;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs [10];

  jk_sync #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .J     (j4),
    .K     (k4),
    .Q     (q4),
    .Qn    (qn4)
  );

  jk_sync dut1 (
    .clk   (clk),
    .reset (rst1),
    .J     (j1),
    .K     (k1),
    .Q     (q1),
    .Qn    (qn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drive the 1-bit instance, then let one rising edge sample it and settle.
  task automatic applyStimulus(input logic rst, input logic j, input logic k);
    rst1 = rst;
    j1   = j;
    k1   = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic exp_q);
    checkOutput({name, " Q"},  {3'b000, q1},  {3'b000, exp_q});
    checkOutput({name, " Qn"}, {3'b000, qn1}, {3'b000, ~exp_q});
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    rst4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    rst1 = 1'b0; j1 = 1'b0;    k1 = 1'b0;

    vecs[0] = '{1'b0, 4'b1111, 4'b0000, 4'b1010};
    vecs[1] = '{1'b1, 4'b1100, 4'b0110, 4'b1100};
    vecs[2] = '{1'b1, 4'b0000, 4'b0000, 4'b1100};
    vecs[3] = '{1'b1, 4'b1111, 4'b1111, 4'b0011};
    vecs[4] = '{1'b1, 4'b1111, 4'b1111, 4'b1100};
    vecs[5] = '{1'b1, 4'b0101, 4'b1010, 4'b0101};
    vecs[6] = '{1'b1, 4'b0000, 4'b1111, 4'b0000};
    vecs[7] = '{1'b1, 4'b1001, 4'b0001, 4'b1001};
    vecs[8] = '{1'b0, 4'b1111, 4'b1111, 4'b1010};
    vecs[9] = '{1'b1, 4'b0011, 4'b1100, 4'b0011};

    #1;
    for (int i = 0; i < 10; i++) begin
      rst4 = vecs[i].rst;
      j4   = vecs[i].j;
      k4   = vecs[i].k;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d Q", i),  q4,  vecs[i].exp_q);
      checkOutput($sformatf("vec%0d Qn", i), qn4, ~vecs[i].exp_q);
    end
    rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;

    // Reset wins over J=1, then normal operation resumes on the next edge.
    applyStimulus(1'b0, 1'b1, 1'b0);
    check1("reset", 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    check1("post-reset set", 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1);
    check1("clear", 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check1("hold a", 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check1("hold b", 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      check1($sformatf("toggle%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // A short reset pulse between edges must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0);
    check1("set before pulse", 1'b1);
    j1 = 1'b0;
    #2 rst1 = 1'b0;
    #2 rst1 = 1'b1;
    #1;
    check1("mid-period pulse", 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check1("after pulse edge", 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    check1("reset over toggle", 1'b0);

    // J/K glitches that are gone before the edge leave Q alone.
    rst1 = 1'b1;
    #1 j1 = 1'b1; k1 = 1'b0;
    #1 j1 = 1'b1; k1 = 1'b1;
    #1 j1 = 1'b0; k1 = 1'b1;
    #1 j1 = 1'b0; k1 = 1'b0;
    @(posedge clk);
    #1;
    check1("glitch from 0", 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    check1("set before glitch", 1'b1);
    #1 j1 = 1'b0; k1 = 1'b1;
    #1 j1 = 1'b1; k1 = 1'b1;
    #1 j1 = 1'b0; k1 = 1'b0;
    @(posedge clk);
    #1;
    check1("glitch from 1", 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/jk_sync.md
JK_SYNC -- requirements
Module: jk_sync

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent JK bit-slices.
REQ-002 The block SHALL have parameter RESET_VALUE, default all-zeros (WIDTH bits), giving the value Q takes on reset.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-low reset (0 = reset asserted), sampled on the rising edge of clk.
REQ-005 The block SHALL have port J, input, WIDTH bits, per-bit set/toggle request.
REQ-006 The block SHALL have port K, input, WIDTH bits, per-bit clear/toggle request.
REQ-007 The block SHALL have port Q, output, WIDTH bits, registered flip-flop state.
REQ-008 The block SHALL have port Qn, output, WIDTH bits, bitwise complement of Q, combinational from the Q register.

Function
REQ-009 Q SHALL change only on the rising edge of clk; J, K and reset changes between edges SHALL have no effect on Q.
REQ-010 Each bit i SHALL be updated independently from J[i], K[i] and Q[i].
REQ-011 When J[i]=0 and K[i]=0 at the edge, Q[i] SHALL hold.
REQ-012 When J[i]=0 and K[i]=1 at the edge, Q[i] SHALL become 0.
REQ-013 When J[i]=1 and K[i]=0 at the edge, Q[i] SHALL become 1.
REQ-014 When J[i]=1 and K[i]=1 at the edge, Q[i] SHALL invert, toggling once per rising edge while both inputs stay 1.
REQ-015 Latency from a J/K change to Q SHALL be exactly one rising edge (the first edge at which the new J/K is sampled).
REQ-016 Qn SHALL equal ~Q at all times, with no extra register stage.
REQ-017 X/Z values on J or K SHALL NOT be given defined behaviour; the design SHALL NOT infer latches.

Reset
REQ-018 When reset=0 at a rising edge of clk, Q SHALL load RESET_VALUE and Qn SHALL be its complement, regardless of J and K.
REQ-019 Reset SHALL take priority over every JK combination, including J=K=1.
REQ-020 Reset SHALL have no asynchronous path: asserting reset between edges SHALL NOT change Q until the next rising edge.
REQ-021 On the first edge with reset=1 after reset, normal JK operation SHALL resume, using the J and K sampled at that edge.
REQ-022 The Q value before the first reset edge SHALL be undefined; a bench SHALL apply reset before checking Q.

Verification
REQ-023 Reset scenario: hold reset=0 with J=1, K=0 for one edge -> Q=0 and Qn=1 after that edge, and Q=1 at the first edge after reset=1.
REQ-024 Set/clear scenario: reset=1; J=1,K=0 for one edge -> Q=1; then J=0,K=1 for one edge -> Q=0; then J=0,K=0 for two edges -> Q stays 0.
REQ-025 Toggle scenario: from Q=0, hold J=1,K=1 for four edges -> Q sequence 1,0,1,0, with Qn always the complement.
REQ-026 Sync-reset scenario: with Q=1, pulse reset=0 for less than one clock period and clear of any rising edge -> Q remains 1; then hold reset=0 across an edge with J=K=1 -> Q=0.
REQ-027 Between-edge scenario: change J/K several times within one clock period and return them to J=0,K=0 before the edge -> Q unchanged at the edge.
REQ-028 Multi-bit scenario: WIDTH=4, RESET_VALUE=4'b1010; reset edge -> Q=1010; then J=1100, K=0110 for one edge -> Q=1100 (bit3 set, bit2 toggles 0->1, bit1 cleared, bit0 held 0).
